// File: rtl/camera_capture_sequencer.sv
// Camera capture sequencer: issues a trigger pulse to the selected camera,
// waits for a fresh frame start, counts lines until frame end and reports
// either a good frame or a sticky timeout / capture-failure error.
module camera_capture_sequencer #(
  parameter int TRIG_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 10_000_000,
  parameter int EXPECTED_LINES = 1944
) (
  input  logic        sysClk,
  input  logic        hard_reset,
  input  logic        trigger,
  input  logic        cam_id,
  input  logic [15:0] trigger_index,
  input  logic [27:0] timestamp,
  input  logic        FV_0,
  input  logic        LV_0,
  input  logic        FV_1,
  input  logic        LV_1,
  output logic        trigger_0,
  output logic        trigger_1,
  output logic        busy,
  output logic        cam_sel,
  output logic [15:0] meta_index,
  output logic [27:0] meta_timestamp,
  output logic        image_metadata_valid,
  output logic        frame_done,
  output logic [11:0] line_count,
  output logic        camera_timeout_error_flag,
  output logic        image_capture_failure_flag,
  output logic        error_flag_valid,
  output logic        request_rejected
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TRIG    = 3'd1,
    WAIT_FV = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4,
    ERR     = 3'd5
  } state_t;

  localparam logic [7:0]  TRIG_LAST    = 8'(TRIG_CYCLES - 1);
  localparam logic [23:0] TIMEOUT_LAST = 24'(TIMEOUT_CYCLES - 1);
  localparam logic [11:0] LINES_GOOD   = 12'(EXPECTED_LINES);

  state_t      state_r;
  logic [7:0]  trig_cnt_r;
  logic [23:0] timer_r;
  logic        prev_fv_r;
  logic        prev_lv_r;

  logic        sel_fv_s;
  logic        sel_lv_s;
  logic        fv_rise_s;
  logic        fv_fall_s;
  logic        lv_rise_s;
  logic [11:0] line_next_s;

  // Select the active camera's FV/LV, detect edges, and form the next line count.
  always_comb begin
    sel_fv_s    = 1'b0;
    sel_lv_s    = 1'b0;
    line_next_s = line_count;
    if (cam_sel) begin
      sel_fv_s = FV_1;
      sel_lv_s = LV_1;
    end else begin
      sel_fv_s = FV_0;
      sel_lv_s = LV_0;
    end
    fv_rise_s = sel_fv_s & ~prev_fv_r;
    fv_fall_s = ~sel_fv_s & prev_fv_r;
    lv_rise_s = sel_lv_s & ~prev_lv_r;
    // Line count saturates so a runaway camera cannot wrap back to a valid count.
    if (lv_rise_s && (line_count != 12'hFFF)) begin
      line_next_s = line_count + 12'd1;
    end else begin
      line_next_s = line_count;
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge sysClk) begin
    if (hard_reset) begin
      state_r                    <= IDLE;
      trig_cnt_r                 <= 8'd0;
      timer_r                    <= 24'd0;
      prev_fv_r                  <= 1'b0;
      prev_lv_r                  <= 1'b0;
      trigger_0                  <= 1'b0;
      trigger_1                  <= 1'b0;
      busy                       <= 1'b0;
      cam_sel                    <= 1'b0;
      meta_index                 <= 16'd0;
      meta_timestamp             <= 28'd0;
      image_metadata_valid       <= 1'b0;
      frame_done                 <= 1'b0;
      line_count                 <= 12'd0;
      camera_timeout_error_flag  <= 1'b0;
      image_capture_failure_flag <= 1'b0;
      error_flag_valid           <= 1'b0;
      request_rejected           <= 1'b0;
    end else begin
      // Edge history follows the selected camera every cycle, so a frame
      // already in progress when WAIT_FV is entered shows no rising edge.
      prev_fv_r            <= sel_fv_s;
      prev_lv_r            <= sel_lv_s;
      image_metadata_valid <= 1'b0;
      frame_done           <= 1'b0;
      error_flag_valid     <= 1'b0;
      request_rejected     <= trigger & (state_r != IDLE);

      case (state_r)
        IDLE: begin
          if (trigger) begin
            cam_sel                    <= cam_id;
            meta_index                 <= trigger_index;
            meta_timestamp             <= timestamp;
            camera_timeout_error_flag  <= 1'b0;
            image_capture_failure_flag <= 1'b0;
            line_count                 <= 12'd0;
            trig_cnt_r                 <= 8'd0;
            trigger_0                  <= ~cam_id;
            trigger_1                  <= cam_id;
            busy                       <= 1'b1;
            state_r                    <= TRIG;
          end else begin
            busy <= 1'b0;
          end
        end
        TRIG: begin
          if (trig_cnt_r == TRIG_LAST) begin
            trigger_0 <= 1'b0;
            trigger_1 <= 1'b0;
            timer_r   <= 24'd0;
            state_r   <= WAIT_FV;
          end else begin
            trig_cnt_r <= trig_cnt_r + 8'd1;
          end
        end
        WAIT_FV: begin
          // A frame start arriving on the timeout cycle still wins.
          if (fv_rise_s) begin
            image_metadata_valid <= 1'b1;
            state_r              <= CAPTURE;
          end else if (timer_r == TIMEOUT_LAST) begin
            camera_timeout_error_flag <= 1'b1;
            error_flag_valid          <= 1'b1;
            state_r                   <= ERR;
          end else begin
            timer_r <= timer_r + 24'd1;
          end
        end
        CAPTURE: begin
          line_count <= line_next_s;
          // A line edge coincident with frame end belongs to this frame.
          if (fv_fall_s) begin
            if (line_next_s == LINES_GOOD) begin
              frame_done <= 1'b1;
              state_r    <= DONE;
            end else begin
              image_capture_failure_flag <= 1'b1;
              error_flag_valid           <= 1'b1;
              state_r                    <= ERR;
            end
          end else begin
            state_r <= CAPTURE;
          end
        end
        DONE: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        ERR: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          trigger_0 <= 1'b0;
          trigger_1 <= 1'b0;
          busy      <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule
